// File: rtl/uart_loop_fifo.sv
// Elastic byte FIFO between uart_rx and uart_tx: captures rx_done bytes and replays
// them one at a time, waiting for tx_done (or a watchdog) between send_en pulses.
module uart_loop_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_done,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  send_en,
    input  logic                  tx_done,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  tx_timeout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  send_q, send_d;
    logic                  ovf_q, ovf_d;
    logic                  tout_q, tout_d;
    logic                  do_pop, do_wr;

    always_comb begin
        // Pop decision uses the pre-edge count, so a byte written this edge waits one cycle.
        do_pop    = (state_q == ST_IDLE) && (count_q != '0);
        do_wr     = rx_done && ((count_q != FULL_CNT) || do_pop);
        state_d   = state_q;
        wr_ptr_d  = do_wr  ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(do_wr) - CNT_W'(do_pop);
        wd_d      = wd_q;
        tx_data_d = tx_data_q;
        send_d    = 1'b0;
        ovf_d     = ovf_q | (rx_done & ~do_wr);
        tout_d    = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (do_pop) begin
                    tx_data_d = mem[rd_ptr_q];
                    send_d    = 1'b1;
                    wd_d      = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (tx_done) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    // The stalled byte is treated as sent; flag it and move on.
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            tx_data_q <= '0;
            send_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            tx_data_q <= tx_data_d;
            send_q    <= send_d;
            ovf_q     <= ovf_d;
            tout_q    <= tout_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign send_en    = send_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign tx_timeout = tout_q;
endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the loopback buffer.
module tb_uart_loop_fifo;
    localparam int T     = 40;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] tx_data;
    logic       send_en;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       tx_timeout;

    uart_loop_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .send_en(send_en), .tx_done(tx_done),
        .fifo_count(fifo_count), .overflow(overflow), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending bytes, whether a byte is out with the transmitter,
    // and how many edges have passed since it was handed over.
    logic [7:0] q[$];
    bit         m_busy;
    int         m_since;
    logic [7:0] m_tx;
    bit         m_send, m_ovf, m_tout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_busy = 0; m_since = 0; m_tx = '0;
        m_send = 0; m_ovf = 0; m_tout = 0;
    endtask

    task automatic model_edge(input bit rxd, input logic [7:0] d, input bit txd);
        bit was_busy;
        bit pop;
        int sz;
        was_busy = m_busy;
        sz       = q.size();
        pop      = !was_busy && (sz > 0);
        if (was_busy) begin
            m_since++;
            if (txd) m_busy = 0;
            else if (m_since == T) begin m_tout = 1; m_busy = 0; end
        end
        if (pop) begin
            m_tx = q.pop_front();
            m_busy = 1;
            m_since = 0;
        end
        m_send = pop;
        if (rxd) begin
            if (sz < DEPTH || pop) q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        check("send_en", 32'(send_en), 32'(m_send));
        check("tx_data", 32'(tx_data), 32'(m_tx));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("tx_timeout", 32'(tx_timeout), 32'(m_tout));
    endtask

    // Called just after a rising edge; applies inputs for the next edge and checks after it.
    task automatic step(input bit rxd, input logic [7:0] d, input bit txd);
        rx_done = rxd; rx_data = d; tx_done = txd;
        @(posedge clk);
        model_edge(rxd, d, txd);
        #1;
        rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'($urandom);
        if (m_send) $display("send byte %02h  count %0d", m_tx, q.size());
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_send_en", 32'(send_en), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_timeout", 32'(tx_timeout), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_busy || q.size() > 0); i++) begin
            idle(2);
            step(0, 8'h00, 1);
        end
        idle(2);
    endtask

    initial begin
        model_clear();
        #3;
        do_reset();

        // 1: single byte latency
        step(1, 8'h55, 0);
        check("t1_count_after_write", 32'(fifo_count), 32'd1);
        check("t1_no_bypass", 32'(send_en), 32'd0);
        step(0, 8'h00, 0);
        check("t1_send", 32'(send_en), 32'd1);
        check("t1_data", 32'(tx_data), 32'h55);
        check("t1_count_after_pop", 32'(fifo_count), 32'd0);
        idle(5);
        step(0, 8'h00, 1);
        idle(2);

        // 2: eight bytes while the transmitter is busy
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
        check("t2_count", 32'(fifo_count), 32'd7);
        for (int i = 0; i < 7; i++) begin
            idle(3);
            step(0, 8'h00, 1);
            step(0, 8'h00, 0);
            check("t2_send", 32'(send_en), 32'd1);
            check("t2_order", 32'(tx_data), 32'(8'h02 + 8'(i)));
        end
        drain();

        // 3: overflow with 18 bytes
        for (int i = 0; i < 18; i++) step(1, 8'hA0 + 8'(i), 0);
        check("t3_count_full", 32'(fifo_count), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd1);
        drain();

        // 4: write at full coinciding with a pop
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 8'hC0 + 8'(i), 0);
        step(0, 8'h00, 1);
        check("t4_full_idle", 32'(fifo_count), 32'd16);
        step(1, 8'hEE, 0);
        check("t4_pop_send", 32'(send_en), 32'd1);
        check("t4_count_same", 32'(fifo_count), 32'd16);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        drain();

        // 5a: watchdog fires exactly T cycles after send_en's edge
        do_reset();
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        idle(T - 1);
        check("t5_not_yet", 32'(tx_timeout), 32'd0);
        step(0, 8'h00, 0);
        check("t5_timeout", 32'(tx_timeout), 32'd1);
        step(0, 8'h00, 0);
        check("t5_next_send", 32'(send_en), 32'd1);
        check("t5_next_data", 32'(tx_data), 32'h22);
        drain();

        // 5b: tx_done on the timeout cycle wins
        do_reset();
        step(1, 8'h33, 0);
        step(0, 8'h00, 0);
        idle(T - 1);
        step(0, 8'h00, 1);
        check("t5_done_wins", 32'(tx_timeout), 32'd0);
        idle(3);

        // 6: async reset mid-WAIT with five bytes buffered
        for (int i = 0; i < 6; i++) step(1, 8'h90 + 8'(i), 0);
        check("t6_count5", 32'(fifo_count), 32'd5);
        do_reset();
        step(0, 8'h00, 1);
        check("t6_stray_done", 32'(send_en), 32'd0);
        step(1, 8'h3C, 0);
        step(0, 8'h00, 0);
        check("t6_send", 32'(send_en), 32'd1);
        check("t6_data", 32'(tx_data), 32'h3C);
        step(0, 8'h00, 1);
        idle(2);

        // random traffic
        do_reset();
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 5) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
- Elastic byte buffer between uart_rx and uart_tx in the USB loopback path.
- Captures every byte flagged by rx_done and replays it to uart_tx with one send_en pulse per byte.
- Holds each byte stable and waits for tx_done before issuing the next one, so back-to-back received bytes are not lost while the transmitter is busy.
- Runs on the SB_HFOSC-derived clk, alongside the other UART stages.

Parameters:
- DATA_W, 8: byte width.
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries (16).
- TIMEOUT_CYC, 100000: clk cycles allowed in WAIT for tx_done before forced recovery. Must exceed one frame time: 9600 baud at 48 MHz is about 50000 cycles.

Ports:
- clk, input, 1: system clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- rx_data, input, DATA_W: received byte; valid only in the cycle rx_done is high.
- rx_done, input, 1: single-cycle strobe from uart_rx.
- tx_data, output, DATA_W: byte presented to uart_tx; held stable from send_en until the next pop.
- send_en, output, 1: single-cycle start strobe to uart_tx.
- tx_done, input, 1: single-cycle completion strobe from uart_tx.
- fifo_count, output, DEPTH_LOG2+1: number of stored bytes, 0..2**DEPTH_LOG2.
- overflow, output, 1: sticky; set when a byte is dropped because the FIFO is full.
- tx_timeout, output, 1: sticky; set when the TIMEOUT_CYC watchdog fires.

Behaviour:
Reset (asynchronous, rst_n=0):
- Pointers and count = 0; state = IDLE; watchdog counter = 0.
- tx_data = 0, send_en = 0, overflow = 0, tx_timeout = 0.
- Memory contents are don't-care.

Storage:
- Circular buffer of 2**DEPTH_LOG2 x DATA_W; wr_ptr/rd_ptr are DEPTH_LOG2 bits and wrap modulo depth.
- fifo_count is a registered value, updated at the same edge as the pointers.

Write:
- On a rising edge with rx_done=1: if pre-edge count < depth, mem[wr_ptr] <= rx_data, wr_ptr++, count++.
- If count == depth, the byte is dropped and overflow <= 1. Exception: when a pop happens at the same edge, the write is accepted and count is unchanged.

State machine:
- IDLE: if pre-edge count > 0, then tx_data <= mem[rd_ptr], rd_ptr++, count--, send_en <= 1, watchdog <= 0, go to WAIT. No bypass: a byte written at edge t is popped no earlier than edge t+1.
- WAIT: send_en <= 0 (high exactly one cycle); watchdog increments each cycle.
  - tx_done=1 -> go to IDLE.
  - Else if watchdog == TIMEOUT_CYC-1 -> tx_timeout <= 1, go to IDLE; the byte is considered sent.
  - tx_done takes priority over timeout in the same cycle.
- A tx_done seen in IDLE is ignored.

Latency and throughput:
- Empty FIFO, rx_done sampled at edge t: send_en is high during the cycle after edge t+1.
- Minimum spacing between send_en pulses is tx_done arrival + 2 cycles.

Simultaneous events:
- Write and pop at the same edge: both take effect, count unchanged.
- A write at full with no pop is dropped, even though WAIT may be about to exit.

Reset mid-operation:
- All state clears immediately. A frame already in flight in uart_tx is not aborted; its later tx_done lands in IDLE and is ignored.
- Buffered bytes are discarded.

Test Plan:
1. Reset, then a single rx_done with rx_data=0x55 at edge t -> send_en high one cycle after edge t+1 with tx_data=0x55; fifo_count goes 1 then 0; no second send_en until tx_done.
2. Eight rx_done pulses carrying 0x01..0x08 while tx_done is withheld -> fifo_count=7 after the first pop. Then pulse tx_done 7 times -> send_en sequence carries 0x02..0x08 in order, each only after the preceding tx_done.
3. Hold tx_done low and write 18 bytes 0xA0..0xB1 -> first byte popped, 16 stored, last byte dropped. overflow=1, fifo_count=16; draining yields 0xA1..0xB0.
4. FIFO full and state IDLE; rx_done coincides with a pop -> new byte accepted, fifo_count stays 16, overflow stays 0.
5. Enter WAIT and never assert tx_done -> exactly TIMEOUT_CYC cycles later tx_timeout=1, state returns to IDLE, next byte sent. Also assert tx_done in the same cycle as the timeout -> tx_timeout stays 0.
6. Deassert rst_n asynchronously mid-WAIT with fifo_count=5 -> outputs clear without waiting for a clk edge. A subsequent stray tx_done produces no send_en; a new byte 0x3C is sent normally.
